// File: rtl/fetch_decode_pkg.sv
// -----------------------------------------------------------------------------
// fetch_decode_pkg
//   Shared definitions for the fetch/decode sequencer:
//   - op_t        : 4-bit opcode enumeration
//   - state_t     : sequencer FSM states
//   - ctrl_t      : decoded control bundle (strobes, status expectations,
//                   register selects)
//   - field offsets of the 32-bit instruction word
// -----------------------------------------------------------------------------
package fetch_decode_pkg;

  // Instruction word layout:
  // op[31:28] dest[27:23] src1[22:18] src2[17:13] eqx[12] ltx[11], rest ignored
  localparam int OP_LO   = 28;
  localparam int OP_W    = 4;
  localparam int DEST_LO = 23;
  localparam int SRC1_LO = 18;
  localparam int SRC2_LO = 13;
  localparam int EQX_BIT = 12;
  localparam int LTX_BIT = 11;
  localparam int REG_W   = 5;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_LDI  = 4'h3,
    OP_ST   = 4'h4,
    OP_CMP  = 4'h5,
    OP_CLR  = 4'h6,
    OP_BR   = 4'h7,
    OP_JMP  = 4'h8,
    OP_HALT = 4'hF
  } op_t;

  typedef enum logic [2:0] {
    FETCH,
    ISSUE,
    HOLD,
    RESOLVE,
    HALT
  } state_t;

  typedef struct packed {
    logic             alu_sum;
    logic             wb;
    logic             mem_wb;
    logic             imm_wb;
    logic             eq_in;
    logic             lt_in;
    logic             reset_st;
    logic             set_st;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] source1;
    logic [REG_W-1:0] source2;
  } ctrl_t;

endpackage

// File: rtl/fd_decoder.sv
// -----------------------------------------------------------------------------
// fd_decoder
//   Purely combinational instruction decoder.
//   Ports:
//     ir         in  IW   instruction word to decode
//     ctrl       out      strobes, eq/lt expectations and register selects
//     needs_hold out 1    instruction writes back a register (extra HOLD cycle)
//     is_branch  out 1    BR or JMP (target resolved in RESOLVE)
//     is_jmp     out 1    unconditional JMP
//     is_halt    out 1    HALT
//     illegal    out 1    undefined opcode (decoded as NOP)
// -----------------------------------------------------------------------------
module fd_decoder
  import fetch_decode_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic [IW-1:0] ir,
  output ctrl_t         ctrl,
  output logic          needs_hold,
  output logic          is_branch,
  output logic          is_jmp,
  output logic          is_halt,
  output logic          illegal
);

  op_t  op;
  logic unused_ir_bits;

  assign op             = op_t'(ir[OP_LO +: OP_W]);
  assign unused_ir_bits = ^ir[LTX_BIT-1:0];

  always_comb begin
    ctrl         = '0;
    ctrl.dest    = ir[DEST_LO +: REG_W];
    ctrl.source1 = ir[SRC1_LO +: REG_W];
    ctrl.source2 = ir[SRC2_LO +: REG_W];
    needs_hold   = 1'b0;
    is_branch    = 1'b0;
    is_jmp       = 1'b0;
    is_halt      = 1'b0;
    illegal      = 1'b0;
    case (op)
      OP_NOP: ;
      OP_ADD: begin
        ctrl.alu_sum = 1'b1;
        ctrl.wb      = 1'b1;
        needs_hold   = 1'b1;
      end
      OP_SUB: begin
        ctrl.wb    = 1'b1;
        needs_hold = 1'b1;
      end
      OP_LDI:  ctrl.imm_wb   = 1'b1;
      OP_ST:   ctrl.mem_wb   = 1'b1;
      // CMP subtracts without writeback, so it needs no HOLD cycle
      OP_CMP:  ctrl.set_st   = 1'b1;
      OP_CLR:  ctrl.reset_st = 1'b1;
      OP_BR: begin
        ctrl.alu_sum = 1'b1;
        ctrl.eq_in   = ir[EQX_BIT];
        ctrl.lt_in   = ir[LTX_BIT];
        is_branch    = 1'b1;
      end
      OP_JMP: begin
        ctrl.alu_sum = 1'b1;
        is_branch    = 1'b1;
        is_jmp       = 1'b1;
      end
      OP_HALT: is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// -----------------------------------------------------------------------------
// fetch_decode
//   Single-issue, non-pipelined sequencer: fetches an instruction, decodes it
//   and drives the datapath control strobes for one ISSUE cycle. Writeback
//   instructions get one HOLD cycle, BR/JMP get one RESOLVE cycle in which the
//   datapath target (and st_match for BR) picks the next PC.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     imem_addr/imem_req    fetch address (PC) and request, req held to valid
//     imem_valid/imem_data  instruction memory response
//     target, st_match      datapath jump destination and status match
//     alu_sum ... set_st    control strobes (high only in ISSUE)
//     eq_in, lt_in          BR status expectation, held until next issue
//     dest/source1/source2  register selects, held until next issue
//     halted, illegal       sticky status flags
// -----------------------------------------------------------------------------
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int PC_W = 5,
  parameter int IW   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [PC_W-1:0]  imem_addr,
  output logic             imem_req,
  input  logic             imem_valid,
  input  logic [IW-1:0]    imem_data,
  input  logic [PC_W-1:0]  target,
  input  logic             st_match,
  output logic             alu_sum,
  output logic             wb,
  output logic             mem_wb,
  output logic             imm_wb,
  output logic             eq_in,
  output logic             lt_in,
  output logic             reset_st,
  output logic             set_st,
  output logic [REG_W-1:0] dest,
  output logic [REG_W-1:0] source1,
  output logic [REG_W-1:0] source2,
  output logic             halted,
  output logic             illegal
);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [IW-1:0]   ir;
  logic [IW-1:0]   ir_d;
  logic            take;
  ctrl_t           dec;
  logic            dec_hold;
  logic            dec_branch;
  logic            dec_jmp;
  logic            dec_halt;
  logic            dec_illegal;

  // A word is accepted only while a request is outstanding in FETCH.
  assign take      = (state == FETCH) && imem_req && imem_valid;
  assign imem_addr = pc;

  // Decode the word being accepted so the registered outputs are already
  // valid in the ISSUE cycle; in every other state this is simply IR.
  assign ir_d = take ? imem_data : ir;

  fd_decoder #(.IW(IW)) u_dec (
    .ir         (ir_d),
    .ctrl       (dec),
    .needs_hold (dec_hold),
    .is_branch  (dec_branch),
    .is_jmp     (dec_jmp),
    .is_halt    (dec_halt),
    .illegal    (dec_illegal)
  );

  // Instruction register: data only, no reset
  always_ff @(posedge clk) begin
    if (take) ir <= imem_data;
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= '0;
      imem_req <= 1'b0;
      alu_sum  <= 1'b0;
      wb       <= 1'b0;
      mem_wb   <= 1'b0;
      imm_wb   <= 1'b0;
      reset_st <= 1'b0;
      set_st   <= 1'b0;
      eq_in    <= 1'b0;
      lt_in    <= 1'b0;
      dest     <= '0;
      source1  <= '0;
      source2  <= '0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared unless this edge enters ISSUE
      alu_sum  <= 1'b0;
      wb       <= 1'b0;
      mem_wb   <= 1'b0;
      imm_wb   <= 1'b0;
      reset_st <= 1'b0;
      set_st   <= 1'b0;
      case (state)
        FETCH: begin
          imem_req <= 1'b1;
          if (take) begin
            state    <= ISSUE;
            imem_req <= 1'b0;
            alu_sum  <= dec.alu_sum;
            wb       <= dec.wb;
            mem_wb   <= dec.mem_wb;
            imm_wb   <= dec.imm_wb;
            reset_st <= dec.reset_st;
            set_st   <= dec.set_st;
            eq_in    <= dec.eq_in;
            lt_in    <= dec.lt_in;
            dest     <= dec.dest;
            source1  <= dec.source1;
            source2  <= dec.source2;
            illegal  <= illegal | dec_illegal;
          end
        end
        ISSUE: begin
          if (dec_hold) begin
            state <= HOLD;
          end else if (dec_branch) begin
            state <= RESOLVE;
          end else if (dec_halt) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state    <= FETCH;
            pc       <= pc + 1'b1;
            imem_req <= 1'b1;
          end
        end
        HOLD: begin
          state    <= FETCH;
          pc       <= pc + 1'b1;
          imem_req <= 1'b1;
        end
        RESOLVE: begin
          state    <= FETCH;
          pc       <= (dec_jmp || st_match) ? target : pc + 1'b1;
          imem_req <= 1'b1;
        end
        HALT: ;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode
//   Self-checking bench: an instruction-level model tracks PC, selects, BR
//   expectations and sticky flags; an instruction memory responds one cycle
//   after the request (plus random extra wait). Directed sequence followed by
//   random instructions, a reset during RESOLVE and a final HALT.
// -----------------------------------------------------------------------------
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  imem_addr;
  logic        imem_req;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [4:0]  target;
  logic        st_match;
  logic        alu_sum, wb, mem_wb, imm_wb, eq_in, lt_in, reset_st, set_st;
  logic [4:0]  dest, source1, source2;
  logic        halted, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction-level model state
  logic [4:0] m_pc;
  logic [4:0] m_dest, m_s1, m_s2;
  logic       m_eq, m_lt, m_ill, m_halt;

  always #5 clk = ~clk;

  fetch_decode dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .target     (target),
    .st_match   (st_match),
    .alu_sum    (alu_sum),
    .wb         (wb),
    .mem_wb     (mem_wb),
    .imm_wb     (imm_wb),
    .eq_in      (eq_in),
    .lt_in      (lt_in),
    .reset_st   (reset_st),
    .set_st     (set_st),
    .dest       (dest),
    .source1    (source1),
    .source2    (source2),
    .halted     (halted),
    .illegal    (illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc(input int op, input int d, input int s1, input int s2,
                                      input int eqx, input int ltx);
    logic [31:0] w;
    w        = '0;
    w[31:28] = op[3:0];
    w[27:23] = d[4:0];
    w[22:18] = s1[4:0];
    w[17:13] = s2[4:0];
    w[12]    = eqx[0];
    w[11]    = ltx[0];
    return w;
  endfunction

  // Expected strobes {alu_sum, wb, mem_wb, imm_wb, reset_st, set_st} per opcode
  function automatic logic [5:0] ref_strobes(input int op);
    case (op)
      1:       return 6'b110000;
      2:       return 6'b010000;
      3:       return 6'b000100;
      4:       return 6'b001000;
      5:       return 6'b000001;
      6:       return 6'b000010;
      7, 8:    return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic check_outputs(input string ph, input logic [5:0] strb, input logic req);
    check_eq({ph, ".strobes"}, 32'({alu_sum, wb, mem_wb, imm_wb, reset_st, set_st}), 32'(strb));
    check_eq({ph, ".dest"},    32'(dest),     32'(m_dest));
    check_eq({ph, ".source1"}, 32'(source1),  32'(m_s1));
    check_eq({ph, ".source2"}, 32'(source2),  32'(m_s2));
    check_eq({ph, ".eq_lt"},   32'({eq_in, lt_in}), 32'({m_eq, m_lt}));
    check_eq({ph, ".illegal"}, 32'(illegal),  32'(m_ill));
    check_eq({ph, ".halted"},  32'(halted),   32'(m_halt));
    check_eq({ph, ".req"},     32'(imem_req), 32'(req));
  endtask

  task automatic do_reset(input int cycles);
    rst_n      = 1'b0;
    imem_valid = 1'b1;
    imem_data  = $urandom;
    repeat (cycles) tick();
    m_pc = '0; m_dest = '0; m_s1 = '0; m_s2 = '0;
    m_eq = 1'b0; m_lt = 1'b0; m_ill = 1'b0; m_halt = 1'b0;
    check_outputs("reset", 6'b0, 1'b0);
    check_eq("reset.addr", 32'(imem_addr), 32'(0));
    rst_n      = 1'b1;
    imem_valid = 1'b0;
    tick();
    check_eq("release.req", 32'(imem_req), 32'(1));
  endtask

  // Entered just after an edge that put the DUT in FETCH with the request up.
  task automatic run_instr(input logic [31:0] w, input logic [4:0] tgt, input logic match,
                           input int extra_wait, input bit abort_in_resolve);
    int op;
    op = int'(w[31:28]);
    imem_valid = 1'b0;
    check_eq("fetch.req",  32'(imem_req),  32'(1));
    check_eq("fetch.addr", 32'(imem_addr), 32'(m_pc));
    repeat (1 + extra_wait) begin
      tick();
      check_eq("wait.req",  32'(imem_req),  32'(1));
      check_eq("wait.addr", 32'(imem_addr), 32'(m_pc));
    end
    imem_valid = 1'b1;
    imem_data  = w;
    target     = tgt;
    st_match   = match;
    tick();
    // ISSUE: memory bus noise must be ignored from here on
    imem_valid = 1'($urandom_range(0, 1));
    imem_data  = $urandom;
    m_dest = w[27:23];
    m_s1   = w[22:18];
    m_s2   = w[17:13];
    m_eq   = (op == 7) ? w[12] : 1'b0;
    m_lt   = (op == 7) ? w[11] : 1'b0;
    if (op >= 9 && op <= 14) m_ill = 1'b1;
    check_outputs("issue", ref_strobes(op), 1'b0);
    if (op == 1 || op == 2) begin
      tick();
      check_outputs("hold", 6'b0, 1'b0);
      m_pc = m_pc + 5'd1;
    end else if (op == 7 || op == 8) begin
      tick();
      check_outputs("resolve", 6'b0, 1'b0);
      if (abort_in_resolve) begin
        do_reset(1);
        return;
      end
      m_pc = (op == 8 || match) ? tgt : m_pc + 5'd1;
    end else if (op == 15) begin
      m_halt = 1'b1;
      repeat (10) begin
        tick();
        check_outputs("halt", 6'b0, 1'b0);
      end
      return;
    end else begin
      m_pc = m_pc + 5'd1;
    end
    tick();
  endtask

  initial begin
    logic [31:0] r;
    int          op;
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    imem_data  = '0;
    target     = '0;
    st_match   = 1'b0;

    do_reset(2);
    run_instr(enc(1, 3, 1, 2, 0, 0), 5'd0,  1'b0, 0, 1'b0); // ADD @0 -> 1
    run_instr(enc(3, 3, 1, 2, 0, 0), 5'd0,  1'b0, 1, 1'b0); // LDI @1 -> 2
    run_instr(enc(2, 7, 4, 5, 1, 1), 5'd0,  1'b0, 0, 1'b0); // SUB @2 -> 3
    run_instr(enc(5, 0, 6, 7, 0, 0), 5'd0,  1'b0, 2, 1'b0); // CMP @3 -> 4
    run_instr(enc(7, 1, 2, 3, 1, 0), 5'd9,  1'b1, 0, 1'b0); // BR taken @4 -> 9
    run_instr(enc(8, 0, 0, 0, 0, 0), 5'd4,  1'b0, 0, 1'b0); // JMP @9 -> 4
    run_instr(enc(7, 1, 2, 3, 1, 0), 5'd9,  1'b0, 0, 1'b0); // BR not taken @4 -> 5
    run_instr(enc(8, 0, 0, 0, 0, 0), 5'd31, 1'b0, 0, 1'b0); // JMP @5 -> 31
    run_instr(enc(8, 0, 0, 0, 0, 0), 5'd2,  1'b1, 0, 1'b0); // JMP @31 -> 2
    run_instr(enc(8, 0, 0, 0, 1, 1), 5'd31, 1'b0, 0, 1'b0); // JMP @2 -> 31
    run_instr(enc(0, 9, 9, 9, 1, 1), 5'd7,  1'b1, 0, 1'b0); // NOP @31 -> 0
    run_instr(enc(10, 4, 4, 4, 0, 0), 5'd7, 1'b1, 0, 1'b0); // illegal @0 -> 1
    run_instr(enc(6, 2, 2, 2, 0, 0), 5'd0,  1'b0, 0, 1'b0); // CLR, illegal sticky

    for (int i = 0; i < 60; i++) begin
      r  = $urandom;
      op = int'($urandom_range(0, 14));
      r[31:28] = op[3:0];
      run_instr(r, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), 1'b0);
    end

    run_instr(enc(7, 5, 6, 7, 1, 1), 5'd7, 1'b1, 0, 1'b1);  // reset during RESOLVE
    run_instr(enc(4, 1, 2, 3, 0, 0), 5'd0, 1'b0, 0, 1'b0);  // ST @0 -> 1
    run_instr(enc(15, 0, 0, 0, 0, 0), 5'd0, 1'b0, 0, 1'b0); // HALT

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
